calc1_port_driver: RTL and testbench

- Requester-side stage directly upstream of one calc1 port; one instance per port (req1..req4).
- Accepts complete operations (cmd, operand1, operand2) from a host/testbench side into a small FIFO.
- Serialises each operation onto reqN_cmd_in/reqN_data_in per the calc1 two-cycle protocol, keeps at most one operation outstanding, and returns the calc1 response (out_respN/out_dataN) or a timeout to the host.

---
 rtl/calc1_port_driver.sv | 212 +++++++++++++++++++++
 tb/tb_calc1_port_driver.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc1_port_driver.sv
// Requester-side driver for one calc1 port: host operation FIFO, two-cycle request
// serializer, single outstanding op with response/timeout capture. Option: CALC1_DRV_CMD_CHECK_EN.
module calc1_port_driver #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic [0:3]  host_cmd,
  input  logic [0:31] host_op1,
  input  logic [0:31] host_op2,
  output logic [0:3]  req_cmd_out,
  output logic [0:31] req_data_out,
  input  logic [0:1]  out_resp_in,
  input  logic [0:31] out_data_in,
  output logic        res_valid,
  output logic [0:1]  res_resp,
  output logic [0:31] res_data,
  output logic        res_timeout,
  output logic        busy,
  output logic        err_spurious
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TMO_W  = 8;
  localparam int unsigned CMD_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RESP_W = 2;

  typedef struct packed {
    logic [0:CMD_W-1]  cmd;
    logic [0:DATA_W-1] op1;
    logic [0:DATA_W-1] op2;
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND1,
    S_SEND2,
    S_WAIT,
    S_DONE
  } state_t;

`ifdef CALC1_DRV_CMD_CHECK_EN
  function automatic logic cmd_supported(input logic [0:CMD_W-1] cmd);
    return (cmd == CMD_W'(1)) || (cmd == CMD_W'(2)) ||
           (cmd == CMD_W'(5)) || (cmd == CMD_W'(6));
  endfunction
`endif

  op_t               mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              push_c, pop_c;
  op_t               head_c;

  state_t            state, state_nxt;
  logic [TMO_W-1:0]  wait_cnt, wait_cnt_nxt;
  logic [0:DATA_W-1] op2_q, op2_nxt;
  logic [0:CMD_W-1]  req_cmd_nxt;
  logic [0:DATA_W-1] req_data_nxt;
  logic              res_valid_nxt;
  logic [0:RESP_W-1] res_resp_nxt;
  logic [0:DATA_W-1] res_data_nxt;
  logic              res_timeout_nxt;
  logic              busy_nxt;
  logic              host_ready_nxt;
  logic              err_spurious_nxt;

  assign push_c = host_valid && host_ready;
  assign head_c = mem[rd_ptr];

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_nxt = count;
    if (push_c && !pop_c) begin
      count_nxt = count + CNT_W'(1);
    end else if (!push_c && pop_c) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  // Entry storage carries no reset; validity is tracked by count
  always_ff @(posedge c_clk) begin
    if (push_c) begin
      mem[wr_ptr] <= '{cmd: host_cmd, op1: host_op1, op2: host_op2};
    end
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
    end
  end

  // Next state plus next value of every registered output
  always_comb begin
    state_nxt       = state;
    pop_c           = 1'b0;
    wait_cnt_nxt    = wait_cnt;
    op2_nxt         = op2_q;
    req_cmd_nxt     = '0;
    req_data_nxt    = '0;
    res_valid_nxt   = 1'b0;
    res_resp_nxt    = res_resp;
    res_data_nxt    = res_data;
    res_timeout_nxt = res_timeout;

    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop_c = 1'b1;
`ifdef CALC1_DRV_CMD_CHECK_EN
          if (!cmd_supported(head_c.cmd)) begin
            state_nxt       = S_DONE;
            res_valid_nxt   = 1'b1;
            res_resp_nxt    = RESP_W'(3);
            res_data_nxt    = '0;
            res_timeout_nxt = 1'b0;
          end else begin
            state_nxt    = S_SEND1;
            req_cmd_nxt  = head_c.cmd;
            req_data_nxt = head_c.op1;
            op2_nxt      = head_c.op2;
          end
`else
          state_nxt    = S_SEND1;
          req_cmd_nxt  = head_c.cmd;
          req_data_nxt = head_c.op1;
          op2_nxt      = head_c.op2;
`endif
        end
      end
      S_SEND1: begin
        state_nxt    = S_SEND2;
        req_data_nxt = op2_q;
      end
      S_SEND2: begin
        state_nxt    = S_WAIT;
        wait_cnt_nxt = '0;
      end
      S_WAIT: begin
        // A response arriving on the last allowed cycle beats the timeout
        if (out_resp_in != '0) begin
          state_nxt       = S_DONE;
          res_valid_nxt   = 1'b1;
          res_resp_nxt    = out_resp_in;
          res_data_nxt    = out_data_in;
          res_timeout_nxt = 1'b0;
        end else if (wait_cnt == TMO_W'(TIMEOUT - 1)) begin
          state_nxt       = S_DONE;
          res_valid_nxt   = 1'b1;
          res_resp_nxt    = '0;
          res_data_nxt    = '0;
          res_timeout_nxt = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + TMO_W'(1);
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy_nxt         = (state_nxt != S_IDLE) || (count_nxt != '0);
  assign host_ready_nxt   = (count_nxt != CNT_W'(FIFO_DEPTH));
  assign err_spurious_nxt = err_spurious || ((out_resp_in != '0) && (state != S_WAIT));

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      wait_cnt     <= '0;
      op2_q        <= '0;
      req_cmd_out  <= '0;
      req_data_out <= '0;
      res_valid    <= 1'b0;
      res_resp     <= '0;
      res_data     <= '0;
      res_timeout  <= 1'b0;
      busy         <= 1'b0;
      host_ready   <= 1'b1;
      err_spurious <= 1'b0;
    end else begin
      state        <= state_nxt;
      wait_cnt     <= wait_cnt_nxt;
      op2_q        <= op2_nxt;
      req_cmd_out  <= req_cmd_nxt;
      req_data_out <= req_data_nxt;
      res_valid    <= res_valid_nxt;
      res_resp     <= res_resp_nxt;
      res_data     <= res_data_nxt;
      res_timeout  <= res_timeout_nxt;
      busy         <= busy_nxt;
      host_ready   <= host_ready_nxt;
      err_spurious <= err_spurious_nxt;
    end
  end

endmodule

// File: tb/tb_calc1_port_driver.sv
// Bench for calc1_port_driver: the bench plays host and calc1, predicting results from
// calc1 arithmetic rules and the driver's cycle timing.
module tb_calc1_port_driver;

  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 15;

  typedef struct packed {
    logic [0:3]  cmd;
    logic [0:31] op1;
    logic [0:31] op2;
  } op_t;

  logic        c_clk;
  logic        reset;
  logic        host_valid;
  logic        host_ready;
  logic [0:3]  host_cmd;
  logic [0:31] host_op1;
  logic [0:31] host_op2;
  logic [0:3]  req_cmd_out;
  logic [0:31] req_data_out;
  logic [0:1]  out_resp_in;
  logic [0:31] out_data_in;
  logic        res_valid;
  logic [0:1]  res_resp;
  logic [0:31] res_data;
  logic        res_timeout;
  logic        busy;
  logic        err_spurious;

  int  n_cmp = 0;
  int  n_err = 0;
  op_t exp_q[$];

  calc1_port_driver #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .c_clk(c_clk), .reset(reset),
    .host_valid(host_valid), .host_ready(host_ready),
    .host_cmd(host_cmd), .host_op1(host_op1), .host_op2(host_op2),
    .req_cmd_out(req_cmd_out), .req_data_out(req_data_out),
    .out_resp_in(out_resp_in), .out_data_in(out_data_in),
    .res_valid(res_valid), .res_resp(res_resp), .res_data(res_data),
    .res_timeout(res_timeout), .busy(busy), .err_spurious(err_spurious)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // calc1 arithmetic: add/sub flag overflow/underflow, shifts use low 5 bits of op2
  function automatic void calc_ref(input logic [0:3] cmd, input logic [0:31] a,
                                   input logic [0:31] b, output logic [0:1] r,
                                   output logic [0:31] d);
    logic [32:0] s;
    case (cmd)
      4'd1: begin s = {1'b0, a} + {1'b0, b}; d = s[31:0]; r = s[32] ? 2'd2 : 2'd1; end
      4'd2: begin d = a - b; r = (b > a) ? 2'd2 : 2'd1; end
      4'd5: begin d = a << (b % 32); r = 2'd1; end
      4'd6: begin d = a >> (b % 32); r = 2'd1; end
      default: begin d = '0; r = 2'd3; end
    endcase
  endfunction

  function automatic op_t gen_op();
    op_t o;
    case ($urandom_range(0, 3))
      0: o.cmd = 4'd1;
      1: o.cmd = 4'd2;
      2: o.cmd = 4'd5;
      default: o.cmd = 4'd6;
    endcase
    o.op1 = $urandom;
    o.op2 = $urandom;
    return o;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_host_ready"},   64'(host_ready),   64'(1));
    check({tag, "_req_cmd"},      64'(req_cmd_out),  64'(0));
    check({tag, "_req_data"},     64'(req_data_out), 64'(0));
    check({tag, "_res_valid"},    64'(res_valid),    64'(0));
    check({tag, "_res_resp"},     64'(res_resp),     64'(0));
    check({tag, "_res_data"},     64'(res_data),     64'(0));
    check({tag, "_res_timeout"},  64'(res_timeout),  64'(0));
    check({tag, "_busy"},         64'(busy),         64'(0));
    check({tag, "_err_spurious"}, 64'(err_spurious), 64'(0));
  endtask

  task automatic push(input op_t o);
    host_cmd   = o.cmd;
    host_op1   = o.op1;
    host_op2   = o.op2;
    host_valid = 1'b1;
    check("push_ready", 64'(host_ready), 64'(1));
    tick();
    host_valid = 1'b0;
    exp_q.push_back(o);
  endtask

  // Follow the next op through SEND1/SEND2 into the first WAIT cycle
  task automatic serve_start(input int exp_wait, input bit spur, output op_t o);
    int waited = 0;
    o = exp_q.pop_front();
    while (req_cmd_out == 4'd0 && waited < 40) begin
      tick();
      waited++;
    end
    check("send1_cmd",  64'(req_cmd_out),  64'(o.cmd));
    check("send1_data", 64'(req_data_out), 64'(o.op1));
    if (exp_wait >= 0) check("send1_gap", 64'(waited), 64'(exp_wait));
    if (spur) out_resp_in = 2'd1;
    tick();
    host_valid  = 1'b0;
    out_resp_in = 2'd0;
    if (spur) check("spurious_set", 64'(err_spurious), 64'(1));
    check("send2_cmd",  64'(req_cmd_out),  64'(0));
    check("send2_data", 64'(req_data_out), 64'(o.op2));
    tick();
    check("wait_cmd",  64'(req_cmd_out),  64'(0));
    check("wait_data", 64'(req_data_out), 64'(0));
  endtask

  // delay >= TIMEOUT means calc1 never answers
  task automatic serve_finish(input op_t o, input int delay);
    logic [0:1]  r;
    logic [0:31] d;
    int          n;
    calc_ref(o.cmd, o.op1, o.op2, r, d);
    n = (delay >= TIMEOUT) ? TIMEOUT : delay;
    for (int i = 0; i < n; i++) begin
      check("no_early_valid", 64'(res_valid), 64'(0));
      tick();
    end
    if (delay < TIMEOUT) begin
      out_resp_in = r;
      out_data_in = d;
      tick();
      out_resp_in = 2'd0;
      out_data_in = '0;
    end else begin
      r = 2'd0;
      d = '0;
    end
    check("done_valid",   64'(res_valid),   64'(1));
    check("done_resp",    64'(res_resp),    64'(r));
    check("done_data",    64'(res_data),    64'(d));
    check("done_timeout", 64'(res_timeout), 64'(delay >= TIMEOUT));
  endtask

  task automatic idle_check(input logic exp_busy);
    tick();
    check("valid_one_cycle", 64'(res_valid),   64'(0));
    check("idle_busy",       64'(busy),        64'(exp_busy));
    check("idle_req_cmd",    64'(req_cmd_out), 64'(0));
  endtask

  initial begin
    op_t         o, cur;
    op_t         fill [5];
    logic [0:1]  r;
    logic [0:31] d;

    reset = 1'b1; host_valid = 1'b0; host_cmd = '0; host_op1 = '0; host_op2 = '0;
    out_resp_in = '0; out_data_in = '0;
    repeat (2) tick();
    check_reset_outputs("rst");
    reset = 1'b0;
    tick();

    // add 5 + 3
    o = '{cmd: 4'd1, op1: 32'd5, op2: 32'd3};
    push(o);
    check("busy_after_push", 64'(busy), 64'(1));
    serve_start(1, 1'b0, cur);
    serve_finish(cur, 0);
    check("add_resp", 64'(res_resp), 64'(1));
    check("add_data", 64'(res_data), 64'(8));
    idle_check(1'b0);
    check("hold_resp", 64'(res_resp), 64'(1));

    // sub 1 - 2 underflows
    o = '{cmd: 4'd2, op1: 32'd1, op2: 32'd2};
    push(o);
    serve_start(1, 1'b0, cur);
    serve_finish(cur, 3);
    check("sub_resp", 64'(res_resp), 64'(2));
    idle_check(1'b0);

    for (int k = 0; k < 6; k++) begin
      push(gen_op());
      serve_start(1, 1'b0, cur);
      serve_finish(cur, int'($urandom_range(0, TIMEOUT - 1)));
      idle_check(1'b0);
    end

    // Response on the last WAIT cycle beats the timeout
    push(gen_op());
    serve_start(1, 1'b0, cur);
    serve_finish(cur, TIMEOUT - 1);
    check("late_resp_no_timeout", 64'(res_timeout), 64'(0));
    idle_check(1'b0);

    // No response at all
    push(gen_op());
    serve_start(1, 1'b0, cur);
    serve_finish(cur, TIMEOUT);
    idle_check(1'b0);
    check("hold_timeout", 64'(res_timeout), 64'(1));

    // FIFO fill while one op is stalled in WAIT
    push(gen_op());
    serve_start(1, 1'b0, cur);
    for (int i = 0; i < 5; i++) fill[i] = gen_op();
    for (int i = 0; i < 4; i++) begin
      check("fill_ready", 64'(host_ready), 64'(1));
      host_cmd = fill[i].cmd; host_op1 = fill[i].op1; host_op2 = fill[i].op2;
      host_valid = 1'b1;
      tick();
      exp_q.push_back(fill[i]);
    end
    host_cmd = fill[4].cmd; host_op1 = fill[4].op1; host_op2 = fill[4].op2;
    check("full_ready_low", 64'(host_ready), 64'(0));
    check("full_busy", 64'(busy), 64'(1));
    tick();
    check("full_ready_hold", 64'(host_ready), 64'(0));
    calc_ref(cur.cmd, cur.op1, cur.op2, r, d);
    out_resp_in = r; out_data_in = d;
    tick();
    out_resp_in = '0; out_data_in = '0;
    check("stall_valid", 64'(res_valid), 64'(1));
    check("stall_resp",  64'(res_resp),  64'(r));
    check("stall_data",  64'(res_data),  64'(d));
    check("done_ready_low", 64'(host_ready), 64'(0));
    tick();
    check("idle_ready_low", 64'(host_ready), 64'(0));
    tick();
    check("ready_after_pop", 64'(host_ready), 64'(1));
    exp_q.push_back(fill[4]);
    serve_start(0, 1'b0, cur);
    serve_finish(cur, int'($urandom_range(0, TIMEOUT - 1)));
    for (int i = 1; i < 5; i++) begin
      serve_start(2, 1'b0, cur);
      serve_finish(cur, int'($urandom_range(0, TIMEOUT - 1)));
    end
    idle_check(1'b0);
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    // Spurious response during SEND1
    check("spurious_clear", 64'(err_spurious), 64'(0));
    push(gen_op());
    serve_start(1, 1'b1, cur);
    serve_finish(cur, 2);
    idle_check(1'b0);
    check("spurious_sticky", 64'(err_spurious), 64'(1));

    // Asynchronous reset in the middle of WAIT
    push(gen_op());
    serve_start(1, 1'b0, cur);
    tick();
    tick();
    #3;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    tick();
    reset = 1'b0;
    for (int i = 0; i < TIMEOUT + 4; i++) begin
      tick();
      check("post_rst_no_valid", 64'(res_valid), 64'(0));
      check("post_rst_busy",     64'(busy),      64'(0));
    end

    // Unsupported command 4
    o = '{cmd: 4'd4, op1: 32'h11, op2: 32'h22};
    push(o);
`ifdef CALC1_DRV_CMD_CHECK_EN
    check("bad_idle_cmd", 64'(req_cmd_out), 64'(0));
    tick();
    void'(exp_q.pop_front());
    check("bad_valid",    64'(res_valid),    64'(1));
    check("bad_resp",     64'(res_resp),     64'(3));
    check("bad_data",     64'(res_data),     64'(0));
    check("bad_timeout",  64'(res_timeout),  64'(0));
    check("bad_req_cmd",  64'(req_cmd_out),  64'(0));
    check("bad_req_data", 64'(req_data_out), 64'(0));
    idle_check(1'b0);
`else
    serve_start(1, 1'b0, cur);
    serve_finish(cur, 1);
    check("bad_resp", 64'(res_resp), 64'(3));
    idle_check(1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
